// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ single-beat read requests onto one AXI4-Lite read port.
// Optional R-channel watchdog: define AXI_RD_ARB_TIMEOUT_EN.
module axi_read_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [1:0]                    rd_resp,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         ARADDR,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic                          RVALID,
    input  logic [DATA_WIDTH-1:0]         RDATA,
    input  logic [1:0]                    RRESP,
    output logic                          RREADY
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                  state_q;
    logic [PW-1:0]           ptr_q, gidx_q;
    logic [NUM_REQ-1:0]      gnt_q, done_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic                    arvalid_q, rready_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [1:0]              rd_resp_q;

`ifdef AXI_RD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
`endif

    // Rotate requests so bit 0 is the requester at ptr, then take the first set bit.
    logic [NUM_REQ-1:0] rot;
    logic [PW:0]        sum;
    logic               pick_vld;
    logic [PW-1:0]      pick_idx;

    always_comb begin
        rot      = NUM_REQ'({req, req} >> ptr_q);
        sum      = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && rot[i]) begin
                sum = {1'b0, ptr_q} + (PW+1)'(i);
                if (sum >= (PW+1)'(NUM_REQ))
                    sum = sum - (PW+1)'(NUM_REQ);
                pick_vld = 1'b1;
                pick_idx = sum[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rd_data_q <= '0;
            rd_resp_q <= '0;
`ifdef AXI_RD_ARB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q     <= NUM_REQ'(1) << pick_idx;
                        gidx_q    <= pick_idx;
                        araddr_q  <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        arvalid_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= DATA;
`ifdef AXI_RD_ARB_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                    end
                end
                DATA: begin
                    if (RVALID) begin
                        rd_data_q <= RDATA;
                        rd_resp_q <= RRESP;
                        rready_q  <= 1'b0;
                        done_q    <= gnt_q;
                        state_q   <= RESP;
                    end
`ifdef AXI_RD_ARB_TIMEOUT_EN
                    // Slave never answered: complete with DECERR so the requester is released.
                    else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        rd_data_q <= '0;
                        rd_resp_q <= 2'b11;
                        rready_q  <= 1'b0;
                        done_q    <= gnt_q;
                        state_q   <= RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    ptr_q   <= (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;
    assign rd_resp = rd_resp_q;
    assign busy    = (state_q != IDLE);
    assign ARADDR  = araddr_q;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter; completions are checked against a queue of expected results.
module tb_axi_read_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      gnt, done;
    logic [DW-1:0]     rd_data;
    logic [1:0]        rd_resp;
    logic              busy;
    logic [AW-1:0]     ARADDR;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;

    axi_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt), .done(done),
        .rd_data(rd_data), .rd_resp(rd_resp), .busy(busy),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  done;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && done !== '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_done", 64'(done), 64'(e.done));
                    chk("sb_data", 64'(rd_data), 64'(e.data));
                    chk("sb_resp", 64'(rd_resp), 64'(e.resp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // One full transaction for requester idx; req driven to rv for the duration.
    task automatic txn(input logic [N-1:0] rv, input int idx, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [1:0] resp,
                       input int ar_wait, input int r_wait, input bit drop_early, input bit keep);
        exp_t         e;
        logic [N-1:0] oh;
        oh     = N'(1) << idx;
        e.done = oh;
        e.data = data;
        e.resp = resp;
        exp_q.push_back(e);
        req_addr[idx*AW +: AW] = addr;
        req     = rv;
        ARREADY = (ar_wait == 0);
        RVALID  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ARVALID === 1'b1) break;
        end
        if (ARVALID !== 1'b1) begin
            chk("arvalid_timeout", 64'(ARVALID), 64'd1);
            return;
        end
        chk("gnt", 64'(gnt), 64'(oh));
        chk("araddr", 64'(ARADDR), 64'(addr));
        chk("busy", 64'(busy), 64'd1);
        // RVALID noise while RREADY is low must be ignored.
        RVALID = 1'b1;
        RDATA  = ~data;
        for (int j = 0; j < ar_wait; j++) begin
            chk("arvalid_hold", 64'(ARVALID), 64'd1);
            chk("araddr_hold", 64'(ARADDR), 64'(addr));
            for (int m = 0; m < N; m++) begin
                if (m != idx) begin
                    req_addr[m*AW +: AW] = $urandom;
                    req[m] = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
        end
        chk("arvalid_hs", 64'(ARVALID), 64'd1);
        chk("araddr_hs", 64'(ARADDR), 64'(addr));
        req     = rv;
        ARREADY = 1'b1;
        RVALID  = 1'b0;
        @(negedge clk);
        chk("arvalid_drop", 64'(ARVALID), 64'd0);
        chk("rready", 64'(RREADY), 64'd1);
        ARREADY = 1'b0;
        if (drop_early) req[idx] = 1'b0;
        for (int j = 0; j < r_wait; j++) begin
            @(negedge clk);
            chk("rready_hold", 64'(RREADY), 64'd1);
            chk("no_early_done", 64'(done), 64'd0);
        end
        RVALID = 1'b1;
        RDATA  = data;
        RRESP  = resp;
        @(negedge clk);
        RVALID = 1'b0;
        RDATA  = $urandom;
        RRESP  = 2'b00;
        chk("done", 64'(done), 64'(oh));
        chk("rready_drop", 64'(RREADY), 64'd0);
        if (!keep) req = '0;
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("gnt_clear", 64'(gnt), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        ARREADY  = 1'b0;
        RVALID   = 1'b0;
        RDATA    = '0;
        RRESP    = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 64'({gnt, done, busy, ARVALID, RREADY}), 64'd0);
        chk("rst_araddr", 64'(ARADDR), 64'd0);
        chk("rst_rd", 64'({rd_resp, rd_data}), 64'd0);
        rst = 1'b0;

        // Idle with handshake noise on both channels.
        ARREADY = 1'b1;
        RVALID  = 1'b1;
        RDATA   = 32'hBAD0_BAD0;
        repeat (3) @(negedge clk);
        chk("idle", 64'({gnt, done, busy, ARVALID, RREADY}), 64'd0);
        chk("idle_rd", 64'({rd_resp, rd_data}), 64'd0);
        ARREADY = 1'b0;
        RVALID  = 1'b0;

        txn(4'b0010, 1, 32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b0, 1'b0);
        txn(4'b0100, 2, 32'h2000_0040, 32'h1234_5678, 2'b00, 5, 2, 1'b0, 1'b0);
        txn(4'b0001, 0, 32'h0000_0ABC, 32'hCAFE_F00D, 2'b10, 0, 3, 1'b1, 1'b0);
        // ptr is now 1: requester 2 must win over requester 0.
        txn(4'b0101, 2, 32'h0000_0044, 32'h5555_AAAA, 2'b01, 0, 0, 1'b0, 1'b0);

        // Reset in DATA: ptr is 3 here, so requester 1 is granted.
        req     = 4'b0010;
        req_addr[1*AW +: AW] = 32'h0000_7000;
        ARREADY = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ARVALID === 1'b1) break;
        end
        chk("rst_txn_gnt", 64'(gnt), 64'b0010);
        @(negedge clk);
        chk("rst_txn_data", 64'(RREADY), 64'd1);
        ARREADY = 1'b0;
        #2 rst = 1'b1;
        req = 4'b1111;
        #1;
        chk("rst_async", 64'({ARVALID, RREADY, gnt, busy, done}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Round robin with every requester held high.
        txn(4'b1111, 0, 32'h0000_A000, 32'h0A0A_0A0A, 2'b00, 0, 0, 1'b0, 1'b1);
        txn(4'b1111, 1, 32'h0000_A100, 32'h1B1B_1B1B, 2'b00, 0, 1, 1'b0, 1'b1);
        txn(4'b1111, 2, 32'h0000_A200, 32'h2C2C_2C2C, 2'b00, 1, 0, 1'b0, 1'b1);
        txn(4'b1111, 3, 32'h0000_A300, 32'h3D3D_3D3D, 2'b00, 0, 0, 1'b0, 1'b1);
        txn(4'b1111, 0, 32'h0000_A004, 32'h4E4E_4E4E, 2'b00, 0, 0, 1'b0, 1'b0);

`ifdef AXI_RD_ARB_TIMEOUT_EN
        begin
            exp_t e;
            int   cnt;
            e.done = 4'b0010;
            e.data = '0;
            e.resp = 2'b11;
            exp_q.push_back(e);
            req     = 4'b0010;
            req_addr[1*AW +: AW] = 32'h0000_B000;
            ARREADY = 1'b1;
            RVALID  = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (ARVALID === 1'b1) break;
            end
            @(negedge clk);
            ARREADY = 1'b0;
            cnt = 1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done !== '0) break;
                cnt++;
            end
            chk("tmo_cycles", 64'(cnt), 64'd16);
            chk("tmo_resp", 64'({rd_resp, rd_data}), {30'd0, 2'b11, 32'd0});
            req = '0;
            @(negedge clk);
        end
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
